uart_ldpc_bist: RTL and testbench

- Synthesizable built-in self-test sequencer for the UART-with-LDPC datapath (top_main); replaces hand-driven stimulus with an on-chip generator/checker.
- Drives m/tx_start into top_main and checks decoded message on each rx_done, with tx looped back to rx externally.
- Generalised: parametric data width, message count, fixed or LFSR payload mode, per-message timeout, error counting and pass/fail status.

---
 rtl/uart_ldpc_pkg.sv | 15 +
 rtl/bist_lfsr.sv | 31 +++
 rtl/uart_ldpc_bist.sv | 140 ++++++++++++++
 tb/tb_uart_ldpc_bist.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ldpc_pkg.sv
// rtl/uart_ldpc_pkg.sv - shared types and defaults for the UART/LDPC loopback BIST
package uart_ldpc_pkg;

   localparam int         DATA_W_DEF    = 8;
   localparam logic [7:0] LFSR_TAPS_DEF = 8'hB8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT,
      S_CHECK,
      S_FIN
   } bist_state_t;

endpackage

// File: rtl/bist_lfsr.sv
// rtl/bist_lfsr.sv - right-shifting Galois LFSR with parallel load
module bist_lfsr
   import uart_ldpc_pkg::*;
#(
   parameter int                DATA_W = DATA_W_DEF,
   parameter logic [DATA_W-1:0] TAPS   = DATA_W'(LFSR_TAPS_DEF)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load,
   input  logic              i_step,
   input  logic [DATA_W-1:0] i_seed,
   output logic [DATA_W-1:0] o_q
);

   logic [DATA_W-1:0] r_q;

   // load has priority so a new run always starts from its seed
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_seed;
      end else if (i_step) begin
         r_q <= (r_q >> 1) ^ (r_q[0] ? TAPS : '0);
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/uart_ldpc_bist.sv
// rtl/uart_ldpc_bist.sv - loopback generator/checker sequencing messages through top_main
module uart_ldpc_bist
   import uart_ldpc_pkg::*;
#(
   parameter int                DATA_W      = DATA_W_DEF,
   parameter int                NUM_MSGS    = 16,
   parameter int                TIMEOUT_CYC = 200000,
   parameter logic [DATA_W-1:0] LFSR_TAPS   = DATA_W'(LFSR_TAPS_DEF),
   parameter int                CNT_W       = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_mode,
   input  logic [DATA_W-1:0] i_seed,
   output logic [DATA_W-1:0] o_m,
   output logic              o_tx_start,
   input  logic              i_tx_done,
   input  logic              i_rx_done,
   input  logic [DATA_W-1:0] i_message,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_pass,
   output logic              o_timeout_err,
   output logic [CNT_W-1:0]  o_msg_count,
   output logic [CNT_W-1:0]  o_err_count
);

   localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   bist_state_t       r_state;
   logic              r_mode;
   logic              r_tx_seen;
   logic              r_rx_seen;
   logic [DATA_W-1:0] r_msg_cap;
   logic [TO_W-1:0]   r_to_cnt;

   logic              w_load;
   logic              w_step;
   logic [DATA_W-1:0] w_seed;
   logic [DATA_W-1:0] w_payload;
   logic              w_tx_any;
   logic              w_rx_any;
   logic [DATA_W-1:0] w_cap;
   logic              w_last;

   // an all-zero LFSR state would lock up, so seed 0 in LFSR mode becomes 1
   assign w_load   = (r_state == S_IDLE) && i_start;
   assign w_step   = (r_state == S_CHECK) && r_mode;
   assign w_seed   = (i_mode && (i_seed == '0)) ? DATA_W'(1) : i_seed;
   assign w_tx_any = r_tx_seen | i_tx_done;
   assign w_rx_any = r_rx_seen | i_rx_done;
   assign w_cap    = i_rx_done ? i_message : r_msg_cap;
   assign w_last   = (o_msg_count == CNT_W'(NUM_MSGS - 1));

   bist_lfsr #(
      .DATA_W (DATA_W),
      .TAPS   (LFSR_TAPS)
   ) u_lfsr (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_load (w_load),
      .i_step (w_step),
      .i_seed (w_seed),
      .o_q    (w_payload)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_mode        <= 1'b0;
         r_tx_seen     <= 1'b0;
         r_rx_seen     <= 1'b0;
         r_msg_cap     <= '0;
         r_to_cnt      <= '0;
         o_m           <= '0;
         o_tx_start    <= 1'b0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_pass        <= 1'b0;
         o_timeout_err <= 1'b0;
         o_msg_count   <= '0;
         o_err_count   <= '0;
      end else begin
         o_tx_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_mode        <= i_mode;
                  o_msg_count   <= '0;
                  o_err_count   <= '0;
                  o_done        <= 1'b0;
                  o_pass        <= 1'b0;
                  o_timeout_err <= 1'b0;
                  o_busy        <= 1'b1;
                  r_state       <= S_SEND;
               end
            end
            S_SEND: begin
               o_m        <= w_payload;
               o_tx_start <= 1'b1;
               r_tx_seen  <= 1'b0;
               r_rx_seen  <= 1'b0;
               r_to_cnt   <= '0;
               r_state    <= S_WAIT;
            end
            S_WAIT: begin
               // done strobes from this cycle count toward the handshake immediately
               r_tx_seen <= w_tx_any;
               r_rx_seen <= w_rx_any;
               r_msg_cap <= w_cap;
               if (w_tx_any && w_rx_any) begin
                  r_state <= S_CHECK;
               end else if (r_to_cnt == TO_LAST) begin
                  o_timeout_err <= 1'b1;
                  r_state       <= S_FIN;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
            end
            S_CHECK: begin
               if ((r_msg_cap != o_m) && (o_err_count != '1)) begin
                  o_err_count <= o_err_count + 1'b1;
               end
               o_msg_count <= o_msg_count + 1'b1;
               r_state     <= w_last ? S_FIN : S_SEND;
            end
            S_FIN: begin
               o_busy  <= 1'b0;
               o_done  <= 1'b1;
               o_pass  <= (o_err_count == '0) && !o_timeout_err;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_ldpc_bist.sv
// tb/tb_uart_ldpc_bist.sv - randomized loopback bench with payload/count reference model
module tb_uart_ldpc_bist;

   localparam int NM = 4;
   localparam int TO = 100;

   logic        clk = 1'b0;
   logic        rst, start, mode, tx_start, tx_done, rx_done;
   logic        busy, done, pass, timeout_err;
   logic [7:0]  seed, m, message;
   logic [15:0] msg_count, err_count;

   uart_ldpc_bist #(
      .DATA_W(8), .NUM_MSGS(NM), .TIMEOUT_CYC(TO), .LFSR_TAPS(8'hB8), .CNT_W(16)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_seed(seed),
      .o_m(m), .o_tx_start(tx_start), .i_tx_done(tx_done), .i_rx_done(rx_done),
      .i_message(message), .o_busy(busy), .o_done(done), .o_pass(pass),
      .o_timeout_err(timeout_err), .o_msg_count(msg_count), .o_err_count(err_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]    got_q[$];
   int            tx_cyc_q[$];
   int            pulses = 0;
   int            start_cyc = 0;
   int            to_cyc = 0;
   bit            to_seen = 0;
   logic [NM-1:0] corrupt = '0;
   int            order = 0;
   bit            rx_suppress = 0;
   int            last_done_cyc = 0;
   bit            prev_done_valid = 0;

   // Reference payload for message i: seed (or 1 for a zero LFSR seed), then
   // halve and fold in the taps whenever the dropped bit was odd.
   function automatic logic [7:0] exp_pay(input bit md, input logic [7:0] sd, input int i);
      int x;
      x = (md && sd == 8'h00) ? 1 : int'(sd);
      if (md) repeat (i) x = (x / 2) ^ ((x % 2 == 1) ? 'hB8 : 0);
      return x[7:0];
   endfunction

   // Loopback model of top_main plus tx_start monitor.
   initial begin
      bit         pend;
      int         c, dtx, drx, sel;
      logic [7:0] cur;
      pend = 0; c = 0; dtx = 1; drx = 1; cur = '0;
      tx_done = 0; rx_done = 0; message = '0;
      forever begin
         @(negedge clk);
         tx_done = 0;
         rx_done = 0;
         if (timeout_err && busy && !to_seen) begin
            to_seen = 1;
            to_cyc  = cyc;
         end
         if (tx_start) begin
            if (prev_done_valid) begin
               n_cmp++;
               if (cyc !== last_done_cyc + 3) begin
                  n_err++;
                  $display("FAIL gap: tx_start at cycle %0d, required %0d", cyc, last_done_cyc + 3);
               end
            end
            prev_done_valid = 0;
            got_q.push_back(m);
            tx_cyc_q.push_back(cyc);
            cur = m ^ ((pulses < NM && corrupt[pulses]) ? 8'h01 : 8'h00);
            pulses++;
            sel = (order == 3) ? ((pulses % 2 == 1) ? 1 : 2) : order;
            case (sel)
               0: begin dtx = int'($urandom_range(1, 20)); drx = int'($urandom_range(1, 20)); end
               1: begin drx = int'($urandom_range(1, 10)); dtx = drx + int'($urandom_range(1, 10)); end
               default: begin dtx = int'($urandom_range(1, 20)); drx = dtx; end
            endcase
            pend = 1;
            c    = 0;
         end
         if (pend) begin
            c++;
            if (c == dtx) tx_done = 1;
            if (c == drx && !rx_suppress) begin
               rx_done = 1;
               message = cur;
            end
            if (c >= dtx && c >= drx) begin
               pend            = 0;
               last_done_cyc   = cyc;
               prev_done_valid = !rx_suppress;
            end
         end
      end
   end

   task automatic launch(input bit md, input logic [7:0] sd, input logic [NM-1:0] cor,
                         input int ord, input bit sup);
      @(negedge clk);
      mode = md; seed = sd; corrupt = cor; order = ord; rx_suppress = sup;
      got_q.delete(); tx_cyc_q.delete();
      pulses = 0; to_seen = 0; prev_done_valid = 0;
      start = 1;
      start_cyc = cyc;
      @(negedge clk);
      start = 0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
      n_cmp++;
      if (done !== 1'b1) begin
         n_err++;
         $display("FAIL done_wait: done=%b, required 1 within 3000 cycles", done);
      end
   endtask

   task automatic test_reset();
      rst = 1; start = 0; mode = 0; seed = '0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({m, tx_start, busy, done, pass, timeout_err, msg_count, err_count} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: m=%h txs=%b busy=%b done=%b pass=%b to=%b mc=%0d ec=%0d, required all 0",
                  m, tx_start, busy, done, pass, timeout_err, msg_count, err_count);
      end
      rst = 0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({tx_start, busy, done} !== 3'b000) begin
         n_err++;
         $display("FAIL idle_after_reset: txs=%b busy=%b done=%b, required 000", tx_start, busy, done);
      end
   endtask

   task automatic test_fixed();
      launch(1'b0, 8'hDD, '0, 0, 1'b0);
      wait_done();
      n_cmp++;
      if (pulses !== NM) begin n_err++; $display("FAIL fixed_pulses: %0d, required %0d", pulses, NM); end
      foreach (got_q[i]) begin
         n_cmp++;
         if (got_q[i] !== 8'hDD) begin n_err++; $display("FAIL fixed_m[%0d]: %h, required dd", i, got_q[i]); end
      end
      n_cmp++;
      if (((tx_cyc_q.size() > 0) ? tx_cyc_q[0] : -100) - start_cyc !== 2) begin
         n_err++; $display("FAIL start_latency: first tx_start not 2 cycles after start");
      end
      n_cmp++;
      if ({msg_count, err_count, pass, timeout_err, busy} !== {16'(NM), 16'd0, 1'b1, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL fixed_status: mc=%0d ec=%0d pass=%b to=%b busy=%b, required %0d 0 1 0 0",
                  msg_count, err_count, pass, timeout_err, busy, NM);
      end
   endtask

   task automatic test_lfsr();
      launch(1'b1, 8'h01, '0, 0, 1'b0);
      wait_done();
      n_cmp++;
      if (pulses !== NM) begin n_err++; $display("FAIL lfsr_pulses: %0d, required %0d", pulses, NM); end
      foreach (got_q[i]) begin
         n_cmp++;
         if (got_q[i] !== exp_pay(1'b1, 8'h01, i)) begin
            n_err++; $display("FAIL lfsr_m[%0d]: %h, required %h", i, got_q[i], exp_pay(1'b1, 8'h01, i));
         end
      end
      n_cmp++;
      if ({pass, err_count} !== {1'b1, 16'd0}) begin
         n_err++; $display("FAIL lfsr_pass: pass=%b ec=%0d, required 1 0", pass, err_count);
      end
   endtask

   task automatic test_errors();
      launch(1'($urandom_range(0, 1)), 8'($urandom), 4'b0110, 0, 1'b0);
      wait_done();
      n_cmp++;
      if ({err_count, msg_count, pass} !== {16'd2, 16'(NM), 1'b0}) begin
         n_err++; $display("FAIL err_counts: ec=%0d mc=%0d pass=%b, required 2 %0d 0", err_count, msg_count, pass, NM);
      end
   endtask

   task automatic test_timeout();
      launch(1'b0, 8'($urandom), '0, 0, 1'b1);
      wait_done();
      n_cmp++;
      if ({timeout_err, pass, msg_count} !== {1'b1, 1'b0, 16'd0}) begin
         n_err++; $display("FAIL timeout_status: to=%b pass=%b mc=%0d, required 1 0 0", timeout_err, pass, msg_count);
      end
      n_cmp++;
      if (!to_seen || tx_cyc_q.size() != 1 || to_cyc - tx_cyc_q[0] !== TO) begin
         n_err++; $display("FAIL timeout_latency: seen=%b pulses=%0d cycles=%0d, required 1 1 %0d",
                           to_seen, tx_cyc_q.size(), to_cyc - ((tx_cyc_q.size() > 0) ? tx_cyc_q[0] : 0), TO);
      end
   endtask

   task automatic test_order();
      for (int r = 0; r < 2; r++) begin
         launch(1'($urandom_range(0, 1)), 8'($urandom), '0, (r == 0) ? 3 : 2, 1'b0);
         wait_done();
         n_cmp++;
         if ({pulses, msg_count, err_count, timeout_err, pass} !== {NM, 16'(NM), 16'd0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL order%0d: pulses=%0d mc=%0d ec=%0d to=%b pass=%b, required %0d %0d 0 0 1",
                              r, pulses, msg_count, err_count, timeout_err, pass, NM, NM);
         end
      end
   endtask

   task automatic test_reset_midrun();
      logic [7:0] sd;
      int         p;
      launch(1'b0, 8'($urandom), '0, 0, 1'b1);
      for (int i = 0; i < 50 && pulses == 0; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      n_cmp++;
      if ({m, tx_start, busy, done, pass, timeout_err, msg_count, err_count} !== '0) begin
         n_err++; $display("FAIL midrun_reset: outputs not all 0 (busy=%b m=%h)", busy, m);
      end
      p = pulses;
      repeat (150) @(negedge clk);
      n_cmp++;
      if (pulses !== p || busy !== 1'b0) begin
         n_err++; $display("FAIL post_reset_quiet: pulses=%0d busy=%b, required %0d 0", pulses, busy, p);
      end
      sd = 8'($urandom);
      launch(1'b1, sd, '0, 0, 1'b0);
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         seed  = 8'($urandom);
      end
      start = 0;
      n_cmp++;
      if ({done, pulses, msg_count} !== {1'b1, NM, 16'(NM)}) begin
         n_err++; $display("FAIL busy_start: done=%b pulses=%0d mc=%0d, required 1 %0d %0d", done, pulses, msg_count, NM, NM);
      end
      foreach (got_q[i]) begin
         n_cmp++;
         if (got_q[i] !== exp_pay(1'b1, sd, i)) begin
            n_err++; $display("FAIL busy_m[%0d]: %h, required %h", i, got_q[i], exp_pay(1'b1, sd, i));
         end
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         bit            md;
         logic [7:0]    sd;
         logic [NM-1:0] cor;
         md  = 1'($urandom_range(0, 1));
         sd  = (r == 0) ? 8'h00 : 8'($urandom);
         cor = NM'($urandom);
         launch(md, sd, cor, int'($urandom_range(0, 3)), 1'b0);
         wait_done();
         n_cmp++;
         if (pulses !== NM) begin n_err++; $display("FAIL rand%0d_pulses: %0d, required %0d", r, pulses, NM); end
         foreach (got_q[i]) begin
            n_cmp++;
            if (got_q[i] !== exp_pay(md, sd, i)) begin
               n_err++; $display("FAIL rand%0d_m[%0d]: %h, required %h", r, i, got_q[i], exp_pay(md, sd, i));
            end
         end
         n_cmp++;
         if ({err_count, msg_count, pass} !== {16'($countones(cor)), 16'(NM), (cor == '0)}) begin
            n_err++; $display("FAIL rand%0d_status: ec=%0d mc=%0d pass=%b, required %0d %0d %b",
                              r, err_count, msg_count, pass, $countones(cor), NM, (cor == '0));
         end
      end
   endtask

   initial begin
      test_reset();
      test_fixed();
      test_lfsr();
      test_errors();
      test_timeout();
      test_order();
      test_reset_midrun();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
